data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter Depth, default 1024, SHALL give the number of 32-bit words in the array (power of two).
REQ-002 Parameter WaitStates, default 0, SHALL give the extra cycles inserted between request acceptance and response (0..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mem_addr_i  input  32 (rvcpu::addr_t)  byte address of the request.
REQ-006 mem_re  input  1  read request.
REQ-007 mem_we  input  1  write request.
REQ-008 mem_w_sel  input  4  byte-lane write enables; bit i covers data bits 8i+7:8i.
REQ-009 mem_data_i  input  32 (rvcpu::data_t)  write data.
REQ-010 mem_data_o  output  32 (rvcpu::data_t)  read data, valid only while mem_ready=1.
REQ-011 mem_ready  output  1  one-cycle completion pulse.
REQ-012 mem_err  output  1  error flag, valid only while mem_ready=1.

Function
REQ-013 States SHALL be IDLE, BUSY and RESP.
REQ-014 In IDLE or RESP, a request (mem_re|mem_we) SHALL be accepted at the clock edge; addr, re, we, w_sel and data SHALL be captured there, and the requester may change its inputs afterwards.
REQ-015 Transitions on acceptance: WaitStates=0 -> RESP; otherwise -> BUSY with the counter loaded to WaitStates-1.
REQ-016 BUSY SHALL decrement the counter each cycle and go to RESP after the cycle in which the counter is 0; requests during BUSY SHALL be ignored.
REQ-017 RESP SHALL last one cycle with mem_ready=1, then go to IDLE, or follow REQ-015 if a new request is present (back-to-back).
REQ-018 Latency: request accepted at edge N -> mem_ready high in cycle N+1+WaitStates.
REQ-019 Word index SHALL be mem_addr_i[log2(Depth)+1:2].
REQ-020 A write SHALL commit the enabled byte lanes at the acceptance edge; bytes whose w_sel bit is 0 SHALL keep their old value.
REQ-021 Read data SHALL be sampled from the array at the edge entering RESP, so a read accepted right after a write to the same word returns the new data.
REQ-022 Errors, all completing with mem_err=1, no array update and mem_data_o=0:
  - mem_re and mem_we both high;
  - address >= Depth*4;
  - mem_w_sel=4'b1111 with addr[1:0]!=0;
  - mem_w_sel=4'b0011 with addr[0]!=0;
  - read with addr[1:0]!=0.
REQ-023 A write with mem_w_sel=0 SHALL be a legal no-op and complete with mem_err=0.
REQ-024 Outside RESP, mem_ready=0, mem_err=0 and mem_data_o=0.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, counter 0, mem_ready=0, mem_err=0 and mem_data_o=0.
REQ-026 Array contents SHALL NOT be reset.
REQ-027 A write already accepted before reset SHALL remain committed; a read in flight SHALL be dropped with no response.
REQ-028 The first request SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-029 addr_t, data_t, Width and a new mem_state_t enum (IDLE/BUSY/RESP) SHALL live in package rvcpu.
REQ-030 The byte-lane storage array SHALL be a sub-module ram_be (Depth, synchronous byte-enable write, asynchronous read); data_mem holds the FSM, counter, error checks and response registers.

Verification
REQ-031 WaitStates=0: write 0xDEADBEEF to 0x10 with w_sel=1111, then read 0x10 back-to-back -> mem_ready at N+1 and N+2, second response data 0xDEADBEEF, err=0.
REQ-032 WaitStates=3: read 0x10 accepted at edge N -> mem_ready only in cycle N+4; a request pulsed during BUSY produces no response.
REQ-033 Byte lanes: after REQ-031, write 0x000000AA to 0x10 with w_sel=0001 -> reading 0x10 returns 0xDEADBEAA.
REQ-034 Errors: read 0x12 -> err=1, data 0; write with re=we=1 -> err=1 and the word is unchanged; address Depth*4 -> err=1.
REQ-035 Reset mid-op (WaitStates=3): write 0x55 to 0x20 accepted, then rst asserted during BUSY -> outputs 0 immediately, no mem_ready; after release, reading 0x20 returns 0x00000055.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared CPU-side memory types: bus widths, data memory FSM states, response bundle.
package rvcpu;
  localparam int Width = 32;

  typedef logic [Width-1:0] addr_t;
  typedef logic [Width-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Registered completion seen by the requester for one cycle.
  typedef struct packed {
    logic  ready;
    logic  err;
    data_t data;
  } mem_rsp_t;
endpackage

// File: rtl/data_mem_ram_be.sv
// Word array built from four byte lanes: synchronous per-lane write, asynchronous read.
module ram_be
  import rvcpu::*;
#(
  parameter int Depth = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               be,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  data_t                    wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output data_t                    rdata
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane_mem [Depth];

    // Commit this byte only when its lane enable is set; contents are never reset.
    always_ff @(posedge clk) begin
      if (be[l]) lane_mem[waddr] <= wdata[8*l +: 8];
    end

    assign rdata[8*l +: 8] = lane_mem[raddr];
  end
endmodule

// File: rtl/data_mem.sv
// Data memory front end: request capture, wait-state FSM, error checks and response regs.
module data_mem
  import rvcpu::*;
#(
  parameter int Depth      = 1024,
  parameter int WaitStates = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  addr_t      mem_addr_i,
  input  logic       mem_re,
  input  logic       mem_we,
  input  logic [3:0] mem_w_sel,
  input  data_t      mem_data_i,
  output data_t      mem_data_o,
  output logic       mem_ready,
  output logic       mem_err
);
  localparam int         AW     = $clog2(Depth);
  localparam logic [3:0] WsLoad = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);

  // Only what the response still needs is kept; writes are consumed at acceptance.
  typedef struct packed {
    logic [AW-1:0] idx;
    logic          re;
    logic          err;
  } pend_t;

  mem_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  pend_t      live, pend_q, cur;
  logic       accept, oor, misalign;
  data_t      rdata;
  logic [3:0] ram_be_w;
  mem_rsp_t   rsp_q;

  // Decode the incoming request and pick which request the response is built from.
  always_comb begin
    oor      = |mem_addr_i[Width-1:AW+2];
    misalign = (mem_we && mem_w_sel == 4'b1111 && mem_addr_i[1:0] != 2'b00) ||
               (mem_we && mem_w_sel == 4'b0011 && mem_addr_i[0]) ||
               (mem_re && mem_addr_i[1:0] != 2'b00);
    live.idx = mem_addr_i[AW+1:2];
    live.re  = mem_re;
    live.err = (mem_re && mem_we) || oor || misalign;
    accept   = (state == IDLE || state == RESP) && (mem_re || mem_we);
    // With zero wait states the response is formed at the acceptance edge itself.
    cur      = (state == BUSY) ? pend_q : live;
    // Gate with reset so a request held during reset never touches the array.
    ram_be_w = (accept && mem_we && !live.err && rst) ? mem_w_sel : 4'b0000;
  end

  // Next-state and wait counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        if (accept) begin
          if (WaitStates == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = BUSY;
            cnt_nx   = WsLoad;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Hold the accepted request while wait states run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pend_q <= '0;
    else if (accept) pend_q <= live;
  end

  // Response is registered on the edge entering RESP and cleared on every other edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q.ready <= (state_nx == RESP);
      rsp_q.err   <= (state_nx == RESP) && cur.err;
      rsp_q.data  <= (state_nx == RESP && cur.re && !cur.err) ? rdata : '0;
    end
  end

  assign mem_ready  = rsp_q.ready;
  assign mem_err    = rsp_q.err;
  assign mem_data_o = rsp_q.data;

  ram_be #(.Depth(Depth)) u_ram (
    .clk  (clk),
    .be   (ram_be_w),
    .waddr(mem_addr_i[AW+1:2]),
    .wdata(mem_data_i),
    .raddr(cur.idx),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_data_mem.sv
// Bench: WaitStates=0 instance driven from a vector table back-to-back, WaitStates=3
// instance driven by hand sequences (BUSY-ignore, reset in BUSY and in RESP).
module tb_data_mem;
  typedef struct {
    logic        re, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdata, exp_d;
    logic        exp_e, chk_d;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        e, chk_d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [31:0] addr  [2];
  logic        re    [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] wdata [2];
  logic [31:0] rdo   [2];
  logic        rdy   [2];
  logic        err   [2];

  int   ws [2] = '{0, 3};
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem #(.Depth(1024), .WaitStates(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_addr_i(addr[0]), .mem_re(re[0]), .mem_we(we[0]),
    .mem_w_sel(sel[0]), .mem_data_i(wdata[0]), .mem_data_o(rdo[0]),
    .mem_ready(rdy[0]), .mem_err(err[0]));

  data_mem #(.Depth(1024), .WaitStates(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .mem_addr_i(addr[1]), .mem_re(re[1]), .mem_we(we[1]),
    .mem_w_sel(sel[1]), .mem_data_i(wdata[1]), .mem_data_o(rdo[1]),
    .mem_ready(rdy[1]), .mem_err(err[1]));

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request on instance k; optionally push its expected completion.
  task automatic req(int k, logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                     logic [31:0] ed, logic ee, logic cd, logic push);
    exp_t e;
    re[k] = r; we[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
    e.cyc = cyc + 1 + ws[k]; e.d = ed; e.e = ee; e.chk_d = cd;
    if (push) begin
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic idle(int k);
    re[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
  endtask

  function automatic vec_t mk(logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                              logic [31:0] ed, logic ee, logic cd);
    vec_t v;
    v.re = r; v.we = w; v.sel = s; v.addr = a; v.wdata = d;
    v.exp_d = ed; v.exp_e = ee; v.chk_d = cd;
    return v;
  endfunction

  // Scoreboard for the zero-wait instance.
  always @(negedge clk) begin
    exp_t e;
    if (rdy[0]) begin
      if (q0.size() == 0) chk("dut0 spurious ready", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("dut0 latency", cyc, e.cyc);
        chk("dut0 err", {31'd0, err[0]}, {31'd0, e.e});
        if (e.chk_d) chk("dut0 data", rdo[0], e.d);
      end
    end else begin
      chk("dut0 idle outputs zero", rdo[0] | {31'd0, err[0]}, 32'd0);
    end
  end

  // Scoreboard for the three-wait instance.
  always @(negedge clk) begin
    exp_t e;
    if (rdy[1]) begin
      if (q1.size() == 0) chk("dut3 spurious ready", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut3 latency", cyc, e.cyc);
        chk("dut3 err", {31'd0, err[1]}, {31'd0, e.e});
        if (e.chk_d) chk("dut3 data", rdo[1], e.d);
      end
    end else begin
      chk("dut3 idle outputs zero", rdo[1] | {31'd0, err[1]}, 32'd0);
    end
  end

  initial begin
    vec_t tv [18];
    //           re    we    sel   addr       wdata          exp_d          err   chk_d
    tv[0]  = mk(1'b0, 1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,         1'b0, 1'b0);
    tv[1]  = mk(1'b1, 1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF,  1'b0, 1'b1);
    tv[2]  = mk(1'b0, 1'b1, 4'h1, 32'h10,   32'h000000AA, 32'h0,         1'b0, 1'b0);
    tv[3]  = mk(1'b1, 1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEAA,  1'b0, 1'b1);
    tv[4]  = mk(1'b1, 1'b0, 4'h0, 32'h12,   32'h0,        32'h0,         1'b1, 1'b1);
    tv[5]  = mk(1'b1, 1'b1, 4'hF, 32'h10,   32'h12345678, 32'h0,         1'b1, 1'b1);
    tv[6]  = mk(1'b1, 1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEAA,  1'b0, 1'b1);
    tv[7]  = mk(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0,        32'h0,         1'b1, 1'b1);
    tv[8]  = mk(1'b0, 1'b1, 4'hF, 32'h1000, 32'h1,        32'h0,         1'b1, 1'b1);
    tv[9]  = mk(1'b0, 1'b1, 4'hF, 32'h14,   32'h11223344, 32'h0,         1'b0, 1'b0);
    tv[10] = mk(1'b0, 1'b1, 4'h3, 32'h16,   32'h0000BEEF, 32'h0,         1'b0, 1'b0);
    tv[11] = mk(1'b0, 1'b1, 4'h3, 32'h15,   32'h0000FFFF, 32'h0,         1'b1, 1'b1);
    tv[12] = mk(1'b0, 1'b1, 4'hF, 32'h16,   32'hFFFFFFFF, 32'h0,         1'b1, 1'b1);
    tv[13] = mk(1'b0, 1'b1, 4'h0, 32'h14,   32'hFFFFFFFF, 32'h0,         1'b0, 1'b0);
    tv[14] = mk(1'b1, 1'b0, 4'h0, 32'h14,   32'h0,        32'h1122BEEF,  1'b0, 1'b1);
    tv[15] = mk(1'b0, 1'b1, 4'hF, 32'hFFC,  32'hCAFEF00D, 32'h0,         1'b0, 1'b0);
    tv[16] = mk(1'b1, 1'b0, 4'h0, 32'hFFC,  32'h0,        32'hCAFEF00D,  1'b0, 1'b1);
    tv[17] = mk(1'b1, 1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEAA,  1'b0, 1'b1);

    rst[0] = 1'b0; rst[1] = 1'b0;
    idle(0); idle(1);
    repeat (3) step();
    chk("reset dut0 ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset dut3 ready", {31'd0, rdy[1]}, 32'd0);
    chk("reset dut0 data/err", rdo[0] | {31'd0, err[0]}, 32'd0);

    // Release and present the first request together: accepted at the very next edge.
    rst[0] = 1'b1; rst[1] = 1'b1;
    foreach (tv[i]) begin
      req(0, tv[i].re, tv[i].we, tv[i].sel, tv[i].addr, tv[i].wdata,
          tv[i].exp_d, tv[i].exp_e, tv[i].chk_d, 1'b1);
      step();
    end
    idle(0);
    repeat (3) step();

    // Three wait states: seed a word, then read it while a write is pulsed during BUSY.
    req(1, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1);
    step(); idle(1); repeat (5) step();
    req(1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    step();
    req(1, 1'b0, 1'b1, 4'hF, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); idle(1); repeat (5) step();
    req(1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    step(); idle(1); repeat (5) step();

    // Reset during BUSY after a write was accepted: no completion, write survives.
    req(1, 1'b0, 1'b1, 4'hF, 32'h20, 32'h00000055, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); idle(1); step();
    rst[1] = 1'b0;
    #1;
    chk("busy reset ready", {31'd0, rdy[1]}, 32'd0);
    chk("busy reset data/err", rdo[1] | {31'd0, err[1]}, 32'd0);
    repeat (3) step();
    rst[1] = 1'b1;
    req(1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h00000055, 1'b0, 1'b1, 1'b1);
    step(); idle(1); repeat (5) step();

    // Reset while a read response is on the bus: it must vanish without waiting for an edge.
    req(1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); idle(1); repeat (3) step();
    chk("resp before reset ready", {31'd0, rdy[1]}, 32'd1);
    chk("resp before reset data", rdo[1], 32'h00000055);
    rst[1] = 1'b0;
    #1;
    chk("resp reset ready", {31'd0, rdy[1]}, 32'd0);
    chk("resp reset data", rdo[1], 32'd0);
    repeat (2) step();
    rst[1] = 1'b1;
    repeat (4) step();

    chk("dut0 responses drained", q0.size(), 32'd0);
    chk("dut3 responses drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
